// File: rtl/wei_rd_pkg.sv
// Shared types and helpers for the weight-SRAM read controller.
// State encodings, default geometry and instruction-field decode.
package wei_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PREP = 2'b01,
      ST_ARB  = 2'b10,
      ST_READ = 2'b11
   } state_e;

   localparam int NUM_PEB_DEF     = 16;
   localparam int INSTR_WIDTH_DEF = 8;
   localparam int BURST_WIDTH_DEF = 4;
   localparam int ADDR_WIDTH_DEF  = 16;
   localparam int CYC_WIDTH_DEF   = 12;
   localparam int PEB_IDX_W       = $clog2(NUM_PEB_DEF);

   // The burst-length field sits at the bottom of the instruction; the PE field is above it.
   localparam int LEN_LSB = 0;

   // Instructions up to 32 bits wide are decoded through these helpers.
   function automatic logic [31:0] burst_len_m1(input logic [31:0] instr, input int unsigned bw);
      return (instr >> LEN_LSB) & ((32'd1 << bw) - 32'd1);
   endfunction

   function automatic logic [31:0] pe_field(input logic [31:0] instr, input int unsigned bw);
      return instr >> (LEN_LSB + bw);
   endfunction

endpackage

// File: rtl/wei_rr_arb.sv
// Round-robin arbiter: one-hot grant searching from a rotating priority pointer.
// The pointer holds the next channel to favour and moves past each accepted grant.
module wei_rr_arb #(
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_val
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found_s;
   int unsigned   cand_s;

   // Priority search and pointer advance.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      cand_s  = 0;
      ptr_d   = ptr_q;
      for (int i = 0; i < N; i++) begin
         cand_s = (int'(ptr_q) + i) % N;
         if (!found_s && req[cand_s]) begin
            found_s = 1'b1;
            gnt_idx = IW'(cand_s);
         end else begin
            found_s = found_s;
         end
      end
      if (en && found_s) begin
         gnt[gnt_idx] = 1'b1;
         ptr_d        = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
      end else begin
         ptr_d = ptr_q;
      end
      gnt_val = en && found_s;
   end

   // Priority pointer register; only the hard reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/wei_rd_ctrl_gen.sv
// Weight-SRAM read controller: arbitrates PE-block instructions and issues SRAM read bursts.
// Optional macro WEI_RD_STALL_CNT_EN adds a saturating ARB-idle cycle counter output.
module wei_rd_ctrl_gen
   import wei_rd_pkg::*;
#(
   parameter int NUM_PEB     = NUM_PEB_DEF,
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int BURST_WIDTH = BURST_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int CYC_WIDTH   = CYC_WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cfg_start,
   input  logic                             cfg_val,
   output logic                             cfg_rdy,
   input  logic [ADDR_WIDTH-1:0]            cfg_base_addr,
   input  logic [CYC_WIDTH-1:0]             cfg_cyc_num,
   input  logic                             rd_prepare,
   input  logic                             pull_back,
   input  logic [NUM_PEB-1:0]               req_val,
   output logic [NUM_PEB-1:0]               req_rdy,
   input  logic [INSTR_WIDTH*NUM_PEB-1:0]   req_data,
   output logic                             rd_en,
   output logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [$clog2(NUM_PEB)-1:0]       rd_peb,
   output logic [INSTR_WIDTH-BURST_WIDTH-1:0] rd_pe,
   output logic                             rd_last,
   output logic                             rd_done,
   output logic [1:0]                       state
`ifdef WEI_RD_STALL_CNT_EN
   ,
   output logic [31:0]                      stall_cnt
`endif
);

   localparam int PW   = $clog2(NUM_PEB);
   localparam int PE_W = INSTR_WIDTH - BURST_WIDTH;

   state_e                 state_q, state_d;
   logic                   cfg_loaded_q, cfg_loaded_d;
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [CYC_WIDTH-1:0]   cyc_num_q, cyc_num_d;
   logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
   logic [CYC_WIDTH-1:0]   cyc_cnt_q, cyc_cnt_d;
   logic [BURST_WIDTH-1:0] beat_q, beat_d;
   logic [BURST_WIDTH-1:0] len_q, len_d;
   logic [PW-1:0]          peb_q, peb_d;
   logic [PE_W-1:0]        pe_q, pe_d;

   logic                   arb_en_s;
   logic [NUM_PEB-1:0]     gnt_s;
   logic [PW-1:0]          gnt_idx_s;
   logic                   gnt_val_s;
   logic [INSTR_WIDTH-1:0] instr_s;
   logic                   beat_last_s;
   logic                   cyc_last_s;

   // Aborts suppress the grant, so no instruction is consumed in that cycle.
   assign arb_en_s = (state_q == ST_ARB) && !cfg_start && !pull_back;

   wei_rr_arb #(
      .N  (NUM_PEB),
      .IW (PW)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_val),
      .en      (arb_en_s),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s),
      .gnt_val (gnt_val_s)
   );

   assign instr_s     = req_data[int'(gnt_idx_s)*INSTR_WIDTH +: INSTR_WIDTH];
   assign beat_last_s = (beat_q == len_q);
   assign cyc_last_s  = ((cyc_cnt_q + CYC_WIDTH'(1)) == cyc_num_q);

   // Next-state and datapath update, with aborts overriding normal transitions.
   always_comb begin
      state_d      = state_q;
      cfg_loaded_d = cfg_loaded_q;
      base_d       = base_q;
      cyc_num_d    = cyc_num_q;
      ptr_d        = ptr_q;
      cyc_cnt_d    = cyc_cnt_q;
      beat_d       = beat_q;
      len_d        = len_q;
      peb_d        = peb_q;
      pe_d         = pe_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_val) begin
               base_d       = cfg_base_addr;
               cyc_num_d    = cfg_cyc_num;
               cfg_loaded_d = 1'b1;
            end else begin
               cfg_loaded_d = cfg_loaded_q;
            end
            if (rd_prepare && cfg_loaded_q && (cyc_num_q != '0)) begin
               state_d = ST_PREP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PREP: begin
            ptr_d     = base_q;
            cyc_cnt_d = '0;
            state_d   = ST_ARB;
         end
         ST_ARB: begin
            if (gnt_val_s) begin
               len_d   = BURST_WIDTH'(burst_len_m1(32'(instr_s), BURST_WIDTH));
               pe_d    = PE_W'(pe_field(32'(instr_s), BURST_WIDTH));
               peb_d   = gnt_idx_s;
               beat_d  = '0;
               state_d = ST_READ;
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_READ: begin
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
            beat_d = beat_q + BURST_WIDTH'(1);
            if (beat_last_s) begin
               cyc_cnt_d = cyc_cnt_q + CYC_WIDTH'(1);
               state_d   = cyc_last_s ? ST_IDLE : ST_ARB;
            end else begin
               state_d = ST_READ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (cfg_start) begin
         state_d      = ST_IDLE;
         cfg_loaded_d = 1'b0;
         base_d       = base_q;
         cyc_num_d    = cyc_num_q;
      end else if (pull_back) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_d;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cfg_loaded_q <= 1'b0;
         base_q       <= '0;
         cyc_num_q    <= '0;
         ptr_q        <= '0;
         cyc_cnt_q    <= '0;
         beat_q       <= '0;
         len_q        <= '0;
         peb_q        <= '0;
         pe_q         <= '0;
      end else begin
         state_q      <= state_d;
         cfg_loaded_q <= cfg_loaded_d;
         base_q       <= base_d;
         cyc_num_q    <= cyc_num_d;
         ptr_q        <= ptr_d;
         cyc_cnt_q    <= cyc_cnt_d;
         beat_q       <= beat_d;
         len_q        <= len_d;
         peb_q        <= peb_d;
         pe_q         <= pe_d;
      end
   end

   // Read-port outputs come straight from registers, zeroed outside READ.
   assign cfg_rdy = (state_q == ST_IDLE);
   assign req_rdy = gnt_s;
   assign rd_en   = (state_q == ST_READ);
   assign rd_addr = rd_en ? ptr_q : '0;
   assign rd_peb  = rd_en ? peb_q : '0;
   assign rd_pe   = rd_en ? pe_q : '0;
   assign rd_last = rd_en && beat_last_s;
   assign rd_done = rd_en && beat_last_s && cyc_last_s;
   assign state   = state_q;

`ifdef WEI_RD_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of ARB cycles with no request pending.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (cfg_start) begin
         stall_cnt_d = 32'd0;
      end else if ((state_q == ST_ARB) && (req_val == '0) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wei_rd_ctrl_gen.sv
// Bench for wei_rd_ctrl_gen: table-driven burst scenarios, a beat scoreboard and abort sequences.
// Define WEI_RD_STALL_CNT_EN to also exercise the stall counter.
module tb_wei_rd_ctrl_gen;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cfg_start, cfg_val, cfg_rdy;
   logic [15:0]  cfg_base_addr;
   logic [11:0]  cfg_cyc_num;
   logic         rd_prepare, pull_back;
   logic [15:0]  req_val, req_rdy;
   logic [127:0] req_data;
   logic         rd_en, rd_last, rd_done;
   logic [15:0]  rd_addr;
   logic [3:0]   rd_peb, rd_pe;
   logic [1:0]   state;
`ifdef WEI_RD_STALL_CNT_EN
   logic [31:0]  stall_cnt;
`endif

   always #5 clk = ~clk;

   wei_rd_ctrl_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cfg_start     (cfg_start),
      .cfg_val       (cfg_val),
      .cfg_rdy       (cfg_rdy),
      .cfg_base_addr (cfg_base_addr),
      .cfg_cyc_num   (cfg_cyc_num),
      .rd_prepare    (rd_prepare),
      .pull_back     (pull_back),
      .req_val       (req_val),
      .req_rdy       (req_rdy),
      .req_data      (req_data),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_peb        (rd_peb),
      .rd_pe         (rd_pe),
      .rd_last       (rd_last),
      .rd_done       (rd_done),
      .state         (state)
`ifdef WEI_RD_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   typedef struct packed {
      logic [15:0] addr;
      logic [3:0]  peb;
      logic [3:0]  pe;
      logic        last;
      logic        done;
   } beat_t;

   typedef struct {
      logic [15:0] base;
      logic [11:0] cyc;
      int          nb;
      int          ch0;
      logic [7:0]  instr0;
      int          ch1;
      logic [7:0]  instr1;
   } vec_t;

   int          total = 0;
   int          bad = 0;
   beat_t       sb[$];
   logic [15:0] exp_ptr, cur_base;
   vec_t        vecs[3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [15:0] base, input logic [11:0] cyc);
      step();
      cfg_base_addr = base;
      cfg_cyc_num   = cyc;
      cfg_val       = 1'b1;
      chk("cfg_rdy", 64'(cfg_rdy), 64'd1);
      step();
      cfg_val  = 1'b0;
      cur_base = base;
   endtask

   task automatic do_prep();
      step();
      rd_prepare = 1'b1;
      exp_ptr    = cur_base;
      step();
      rd_prepare = 1'b0;
   endtask

   task automatic push_burst(input int ch, input logic [7:0] instr, input bit fin);
      int len;
      beat_t b;
      len = int'(instr[3:0]);
      for (int k = 0; k <= len; k++) begin
         b.addr = exp_ptr;
         b.peb  = 4'(ch);
         b.pe   = instr[7:4];
         b.last = (k == len);
         b.done = fin && (k == len);
         sb.push_back(b);
         exp_ptr = exp_ptr + 16'd1;
      end
   endtask

   // Present one request, check the grant, record the expected burst and wait for its end.
   task automatic grant(input int ch, input logic [7:0] instr, input bit fin);
      bit got;
      logic [15:0] oh;
      req_data[ch*8 +: 8] = instr;
      req_val = 16'h0000;
      req_val[ch] = 1'b1;
      oh = 16'h0001 << ch;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (state == 2'b10) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk("grant_timeout", 64'd0, 64'd1);
      end else begin
         chk("grant", 64'(req_rdy), 64'(oh));
         push_burst(ch, instr, fin);
      end
      step();
      req_val = 16'h0000;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rd_en && rd_last) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("burst_end_timeout", 64'd0, 64'd1);
   endtask

   // Scoreboard monitor: every beat must match the head of the queue.
   always @(negedge clk) begin
      beat_t act, e;
      if (rst_n) begin
         act = {rd_addr, rd_peb, rd_pe, rd_last, rd_done};
         if (rd_en) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL beat_unexpected: got %0h expected none", act);
            end else begin
               e = sb.pop_front();
               chk("beat", 64'(act), 64'(e));
            end
         end else begin
            chk("done_without_beat", 64'(rd_done), 64'd0);
         end
      end
   end

   initial begin
      bit got;
      logic [15:0] oh;
      beat_t b;

      vecs[0] = '{base: 16'h0100, cyc: 12'd2, nb: 2, ch0: 3,  instr0: 8'h52, ch1: 5, instr1: 8'h30};
      vecs[1] = '{base: 16'hFFFE, cyc: 12'd1, nb: 1, ch0: 9,  instr0: 8'hA3, ch1: 0, instr1: 8'h00};
      vecs[2] = '{base: 16'h1234, cyc: 12'd2, nb: 2, ch0: 15, instr0: 8'h61, ch1: 0, instr1: 8'h90};

      rst_n = 1'b0;
      cfg_start = 1'b0; cfg_val = 1'b0; cfg_base_addr = 16'h0; cfg_cyc_num = 12'h0;
      rd_prepare = 1'b0; pull_back = 1'b0; req_val = 16'h0; req_data = 128'h0;
      exp_ptr = 16'h0; cur_base = 16'h0;
      #23;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_rd_addr", 64'(rd_addr), 64'd0);
      chk("rst_rd_done", 64'(rd_done), 64'd0);
      chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
      rst_n = 1'b1;

      // Round robin with all channels requesting, single-beat bursts, pointer fresh from reset.
      do_cfg(16'h0000, 12'd20);
      for (int c = 0; c < 16; c++) req_data[c*8 +: 8] = {4'(c), 4'h0};
      do_prep();
      req_val = 16'hFFFF;
      for (int k = 0; k < 20; k++) begin
         got = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state == 2'b10) begin
               got = 1'b1;
               break;
            end else if (state == 2'b11) begin
               chk("rdy_in_read", 64'(req_rdy), 64'd0);
            end
         end
         if (!got) begin
            chk("rr_timeout", 64'd0, 64'd1);
         end else begin
            oh = 16'h0001 << (k % 16);
            chk("rr_grant", 64'(req_rdy), 64'(oh));
            b = '{addr: exp_ptr, peb: 4'(k % 16), pe: 4'(k % 16), last: 1'b1, done: (k == 19)};
            sb.push_back(b);
            exp_ptr = exp_ptr + 16'd1;
         end
      end
      step();
      step();
      req_val = 16'h0000;
      chk("rr_idle", 64'(state), 64'd0);

      // Table-driven bursts: multi-burst cycles, address wrap, arbiter wrap.
      for (int v = 0; v < 3; v++) begin
         do_cfg(vecs[v].base, vecs[v].cyc);
         do_prep();
         grant(vecs[v].ch0, vecs[v].instr0, vecs[v].nb == 1);
         if (vecs[v].nb > 1) grant(vecs[v].ch1, vecs[v].instr1, 1'b1);
         step();
         chk("idle_after_done", 64'(state), 64'd0);
      end

      // pull_back on beat 2 of an 8-beat burst, then restart from base.
      do_cfg(16'h0200, 12'd1);
      do_prep();
      req_data[7*8 +: 8] = 8'h17;
      req_val = 16'h0080;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (state == 2'b10) begin
            got = 1'b1;
            break;
         end
      end
      chk("pb_grant", 64'(req_rdy), got ? 64'h0080 : 64'hDEAD);
      for (int k = 0; k < 3; k++) begin
         b = '{addr: 16'h0200 + 16'(k), peb: 4'd7, pe: 4'd1, last: 1'b0, done: 1'b0};
         sb.push_back(b);
      end
      step();
      req_val = 16'h0000;
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 16'h0202) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("pb_beat2_timeout", 64'd0, 64'd1);
      pull_back = 1'b1;
      step();
      pull_back = 1'b0;
      @(negedge clk);
      chk("pb_rd_en", 64'(rd_en), 64'd0);
      chk("pb_state", 64'(state), 64'd0);
      chk("pb_sb_drained", 64'(sb.size()), 64'd0);
      do_prep();
      grant(2, 8'h21, 1'b1);
      step();
      chk("pb_restart_idle", 64'(state), 64'd0);

      // cfg_start beats a simultaneous handshake and rd_prepare; config is dropped.
      step();
      cfg_start = 1'b1; cfg_val = 1'b1; rd_prepare = 1'b1;
      cfg_base_addr = 16'h0500; cfg_cyc_num = 12'd3;
      step();
      cfg_start = 1'b0; cfg_val = 1'b0; rd_prepare = 1'b0;
      chk("cs_state", 64'(state), 64'd0);
      rd_prepare = 1'b1;
      step();
      rd_prepare = 1'b0;
      chk("cs_prep_ignored", 64'(state), 64'd0);
      step();
      chk("cs_prep_ignored2", 64'(state), 64'd0);
      do_cfg(16'h0600, 12'd0);
      do_prep();
      chk("cyc0_ignored", 64'(state), 64'd0);
      do_cfg(16'h0300, 12'd1);
      do_prep();
      chk("reconf_prep", 64'(state), 64'd1);
      grant(4, 8'h40, 1'b1);
      step();
      chk("reconf_idle", 64'(state), 64'd0);

`ifdef WEI_RD_STALL_CNT_EN
      // Seven idle ARB cycles, then cfg_start clears the count.
      step();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      chk("stall_clear0", 64'(stall_cnt), 64'd0);
      do_cfg(16'h0400, 12'd1);
      do_prep();
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (state == 2'b10) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("stall_arb_timeout", 64'd0, 64'd1);
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("stall_cnt7", 64'(stall_cnt), 64'd7);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      chk("stall_cleared", 64'(stall_cnt), 64'd0);
      chk("stall_idle", 64'(state), 64'd0);
`endif

      repeat (3) step();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
